ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Sequences and shares the 16x8 program/data RAM between two requesters: the CPU control unit (fetch/execute) and the program loader (boot-time fill).
- Owns the RAM strobes (ram_in write, ram_out read), the address and the write-data bus driver.
- One access per arbitration round; single-cycle RAM access framed by arbitrate and respond cycles.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, consecutive loader grants allowed while cpu_req is pending before the CPU is forced in (range 1..15).
- PROT_BASE, 4'hC, lowest write-protected address; used only with RAM_ARB_WRPROT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU owns RAM (ACCESS and RESP).
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  protected-write flag, valid with cpu_ack.
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader equivalents.
- ld_gnt, ld_ack  out  1/1  loader equivalents.
- rdata  out  DATA_W  read data, valid while the corresponding ack is high.
- ram_in  out  1  RAM write strobe.
- ram_out  out  1  RAM read/output enable.
- ram_add_4  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  value for the tri-state bus driver.
- ram_wdata_oe  out  1  bus driver enable.
- ram_rdata  in  DATA_W  RAM bus as sampled.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, state IDLE, burst counter 0, latched owner/addr/we/wdata cleared. An access in flight is aborted with no ack. ram_wdata_oe drops immediately, so the bus is released.
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE. Round latency is 3 cycles; back-to-back rounds run every 3 cycles.
- IDLE, no request: state is held.
- IDLE, arbitration:
  - Winner = loader if ld_req, unless cpu_req && burst_cnt == MAX_BURST; otherwise CPU if cpu_req.
  - On the edge, latch owner, we, addr and wdata from the winner, then go to ACCESS.
  - Operands are ignored after latching.
  - A req dropped before this edge is treated as withdrawn; no ack is issued.
- Burst counter:
  - Increments when the loader wins while cpu_req is high; saturates at MAX_BURST.
  - Clears to 0 whenever the CPU wins or cpu_req is low in IDLE.
- ACCESS (1 cycle):
  - ram_add_4 = latched addr; owner gnt = 1.
  - Write: ram_in = 1, ram_out = 0, ram_wdata_oe = 1, ram_wdata = latched data. The RAM captures on the closing edge.
  - Read: ram_out = 1, ram_in = 0, oe = 0. ram_rdata is registered into rdata on the closing edge.
  - ram_in and ram_out are never both 1. ram_wdata_oe is never 1 while ram_out = 1.
- RESP (1 cycle):
  - Owner ack = 1 and gnt stays 1. rdata holds the read value; it is 0 after a write.
  - ram_in, ram_out and oe are 0; ram_add_4 holds.
  - The requester may drop req or present the next request during this cycle. A req still high at the IDLE edge is a new request.
- Non-owner gnt and ack stay 0 for the whole round.
- rdata holds its last value in IDLE. The address is not cleared between rounds.

Optional Feature:
- Macro: RAM_ARB_WRPROT_EN.
- Defined:
  - A CPU write with addr >= PROT_BASE still runs ACCESS/RESP timing, but ram_in and ram_wdata_oe stay 0, so RAM is unchanged.
  - cpu_err = 1 together with cpu_ack.
  - Loader writes and all reads are unaffected.
- Undefined: cpu_err is tied 0 and all writes proceed.

Test Plan:
- Loader write then read: ld write addr 3 data 8'hAF, then ld read addr 3.
  - Write: ram_in high exactly in cycle 2 with ram_add_4 = 3, ld_ack in cycle 3.
  - Read: rdata = 8'hAF with ld_ack.
- CPU reads addr 1, 2, 3 back-to-back (pre-loaded 8'h11/8'h22/8'h33): acks at 3-cycle spacing, rdata 8'h11, 8'h22, 8'h33; cpu_gnt never overlaps ld_gnt.
- Simultaneous req with MAX_BURST = 4, both requesters continuous: grant order is L, L, L, L, C, L, L, L, L, C; the counter resets after each C.
- Reset asserted during the ACCESS cycle of a write to addr 5:
  - All strobes and oe go to 0 within the reset assertion with no clock edge; no ack is issued.
  - RAM addr 5 may hold the old value or the new value; the bench must accept either.
  - Arbitration resumes normally after reset release.
- Withdrawal: cpu_req pulsed for 1 cycle while the loader owns the RAM -> the CPU is never granted and no cpu_ack occurs.
- RAM_ARB_WRPROT_EN defined: CPU write 8'h55 to addr 4'hD -> cpu_ack and cpu_err both high, ram_in never high, and a subsequent read returns the old value. The same write to addr 4'h2 succeeds with cpu_err = 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the 16x8 program/data RAM: the CPU and the boot loader share it.
// Each round runs IDLE -> ACCESS -> RESP. Define RAM_ARB_WRPROT_EN to block CPU writes at or above PROT_BASE.
module ram_arbiter #(
  parameter int unsigned        ADDR_W    = 4,
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        MAX_BURST = 4,
  parameter logic [ADDR_W-1:0]  PROT_BASE = 4'hC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_in,
  output logic              ram_out,
  output logic [ADDR_W-1:0] ram_add_4,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  logic [1:0]        r_state;
  logic              r_owner_cpu;
  logic              r_we;
  logic              r_prot;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_burst;

  logic w_idle;
  logic w_access;
  logic w_resp;
  logic w_ld_win;
  logic w_cpu_win;
  logic w_prot_hit;

`ifdef RAM_ARB_WRPROT_EN
  localparam logic ProtEn = 1'b1;
  assign cpu_err = w_resp && r_owner_cpu && r_prot;
`else
  localparam logic ProtEn = 1'b0;
  assign cpu_err = 1'b0;
`endif

  assign w_idle   = (r_state == StIdle);
  assign w_access = (r_state == StAccess);
  assign w_resp   = (r_state == StResp);

  // Loader has priority until it has starved a waiting CPU for BurstMax rounds.
  assign w_ld_win   = ld_req && !(cpu_req && (r_burst == BurstMax));
  assign w_cpu_win  = cpu_req && !w_ld_win;
  assign w_prot_hit = ProtEn && cpu_we && (cpu_addr >= PROT_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_owner_cpu <= 1'b0;
      r_we        <= 1'b0;
      r_prot      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_burst     <= 4'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_ld_win || w_cpu_win) begin
            r_state     <= StAccess;
            r_owner_cpu <= w_cpu_win;
            r_we        <= w_cpu_win ? cpu_we    : ld_we;
            r_addr      <= w_cpu_win ? cpu_addr  : ld_addr;
            r_wdata     <= w_cpu_win ? cpu_wdata : ld_wdata;
            r_prot      <= w_cpu_win && w_prot_hit;
          end
          if (w_ld_win && cpu_req) begin
            r_burst <= (r_burst == BurstMax) ? r_burst : r_burst + 4'd1;
          end else begin
            r_burst <= 4'd0;
          end
        end
        StAccess: begin
          r_state <= StResp;
          r_rdata <= r_we ? '0 : ram_rdata;
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy    = !w_idle;
  assign cpu_gnt = !w_idle && r_owner_cpu;
  assign ld_gnt  = !w_idle && !r_owner_cpu;
  assign cpu_ack = w_resp && r_owner_cpu;
  assign ld_ack  = w_resp && !r_owner_cpu;
  assign rdata   = r_rdata;

  // Strobes decode from the registered state, so an async reset drops them at once.
  assign ram_in       = w_access && r_we && !r_prot;
  assign ram_out      = w_access && !r_we;
  assign ram_wdata_oe = ram_in;
  assign ram_wdata    = r_wdata;
  assign ram_add_4    = r_addr;

endmodule
